// File: rtl/ram_port_arbiter_pkg.sv
// Shared state encodings and port ids for the RAM port arbiter.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side req/ack bundle: master = pipeline stage, slave = arbiter.
interface ram_port_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic             req;
  logic             wena;
  logic [DEPTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;

  modport master (output req, wena, addr, wdata, input ack, rdata);
  modport slave  (input req, wena, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter_pick.sv
// Winner selection between port A (fetch) and port B (load/store).
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise B wins every tie.
module ram_arb_pick
  import ram_port_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic win_b
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the port that did not win last time goes next.
  assign win_b = b_req & (~a_req | (last_grant == PORT_A));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign win_b = b_req;
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises two req/ack requesters onto one single-port RAM, one access per 3 cycles.
// Tie policy is set by ARB_ROUND_ROBIN_EN (defined: round robin, undefined: B wins).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_port_if.slave        a,
  ram_port_if.slave        b,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             grant_b
);

  arb_state_t       state;
  logic             grant_q;
  logic             a_ack_q;
  logic             b_ack_q;
  logic [WIDTH-1:0] rdata_q;
  logic             wena_q;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             win_b;
  logic             last_grant;
  logic             any_req;
  logic             in_access;

  assign any_req = a.req | b.req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_B;
`endif

  ram_arb_pick u_pick (
    .a_req      (a.req),
    .b_req      (b.req),
    .last_grant (last_grant),
    .win_b      (win_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant_q <= PORT_A;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_B;
`endif
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= win_b;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= win_b;
`endif
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // ram_dout still shows the pre-write word while the write commits on this edge.
          rdata_q <= ram_dout;
          a_ack_q <= (grant_q == PORT_A);
          b_ack_q <= (grant_q == PORT_B);
          state   <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Access fields need no reset: they only reach the RAM while in ST_ACCESS.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && any_req) begin
      wena_q  <= win_b ? b.wena  : a.wena;
      addr_q  <= win_b ? b.addr  : a.addr;
      wdata_q <= win_b ? b.wdata : a.wdata;
    end
  end

  assign in_access = (state == ST_ACCESS);
  assign ram_ena   = in_access;
  assign ram_wena  = in_access & wena_q;
  assign ram_addr  = in_access ? addr_q  : '0;
  assign ram_din   = in_access ? wdata_q : '0;
  assign grant_b   = (state != ST_IDLE) & grant_q;

  assign a.ack   = a_ack_q;
  assign b.ack   = b_ack_q;
  assign a.rdata = rdata_q;
  assign b.rdata = rdata_q;

endmodule
